// File: rtl/poly_note_player.sv
`default_nettype none
// ============================================================================
// poly_note_player : time-multiplexed polyphonic note player with envelopes
// Rev 1.0
// ============================================================================
module poly_note_player #(
  parameter int NUM_VOICES  = 4,
  parameter int VOICE_IDX_W = 2,
  parameter int PHASE_W     = 22,
  parameter int STEP_W      = 20,
  parameter int ROM_ADDR_W  = 10,
  parameter int SAMPLE_W    = 16,
  parameter int DUR_W       = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   play_enable,
  input  logic                   beat,
  input  logic                   load_new_note,
  input  logic [VOICE_IDX_W-1:0] voice_to_load,
  input  logic [STEP_W-1:0]      step_to_load,
  input  logic [DUR_W-1:0]       duration_to_load,
  input  logic [7:0]             level_to_load,
  input  logic [7:0]             attack_to_load,
  input  logic [7:0]             release_to_load,
  input  logic                   generate_next_sample,
  output logic [ROM_ADDR_W-1:0]  rom_addr,
  input  logic [SAMPLE_W-1:0]    rom_data,
  output logic [SAMPLE_W-1:0]    sample_out,
  output logic                   new_sample_ready,
  output logic [NUM_VOICES-1:0]  done_with_note,
  output logic [NUM_VOICES-1:0]  voice_active
);

  localparam int ACC_W = SAMPLE_W + VOICE_IDX_W;

  localparam logic [1:0] V_IDLE    = 2'd0;
  localparam logic [1:0] V_ATTACK  = 2'd1;
  localparam logic [1:0] V_SUSTAIN = 2'd2;
  localparam logic [1:0] V_RELEASE = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [PHASE_W-1:0] phase_q [NUM_VOICES];
  logic [PHASE_W-1:0] phase_d [NUM_VOICES];
  logic [STEP_W-1:0]  step_q  [NUM_VOICES];
  logic [STEP_W-1:0]  step_d  [NUM_VOICES];
  logic [DUR_W-1:0]   dur_q   [NUM_VOICES];
  logic [DUR_W-1:0]   dur_d   [NUM_VOICES];
  logic [7:0]         lvl_q   [NUM_VOICES];
  logic [7:0]         lvl_d   [NUM_VOICES];
  logic [7:0]         atk_q   [NUM_VOICES];
  logic [7:0]         atk_d   [NUM_VOICES];
  logic [7:0]         rel_q   [NUM_VOICES];
  logic [7:0]         rel_d   [NUM_VOICES];
  logic [7:0]         env_q   [NUM_VOICES];
  logic [7:0]         env_d   [NUM_VOICES];
  logic [1:0]         state_q [NUM_VOICES];
  logic [1:0]         state_d [NUM_VOICES];

  logic [1:0]              seq_q, seq_d;
  logic [VOICE_IDX_W-1:0]  vidx_q, vidx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [ROM_ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [SAMPLE_W-1:0]     sample_q, sample_d;
  logic                    ready_q, ready_d;
  logic [NUM_VOICES-1:0]   done_q, done_d;
  logic [NUM_VOICES-1:0]   done_pend_q, done_pend_d;

  logic [8:0]                env_sum;
  logic [7:0]                env_nxt;
  logic [1:0]                st_nxt;
  logic signed [SAMPLE_W+8:0] prod;
  logic signed [ACC_W-1:0]   contrib;
  logic [VOICE_IDX_W-1:0]    vnext;

  always_comb begin
    phase_d     = phase_q;
    step_d      = step_q;
    dur_d       = dur_q;
    lvl_d       = lvl_q;
    atk_d       = atk_q;
    rel_d       = rel_q;
    env_d       = env_q;
    state_d     = state_q;
    seq_d       = seq_q;
    vidx_d      = vidx_q;
    acc_d       = acc_q;
    rom_addr_d  = rom_addr_q;
    sample_d    = sample_q;
    ready_d     = 1'b0;
    done_d      = '0;
    done_pend_d = done_pend_q;
    env_sum     = '0;
    env_nxt     = '0;
    st_nxt      = V_IDLE;
    prod        = '0;
    contrib     = '0;
    vnext       = vidx_q + VOICE_IDX_W'(1);

    case (seq_q)
      S_IDLE: begin
        if (generate_next_sample) begin
          seq_d       = S_ADDR;
          vidx_d      = '0;
          acc_d       = '0;
          done_pend_d = '0;
          rom_addr_d  = phase_q[0][PHASE_W-1 -: ROM_ADDR_W];
        end
      end
      S_ADDR: seq_d = S_ACC;
      S_ACC: begin
        // Paused or idle voices add nothing and keep all of their state.
        if (play_enable && state_q[vidx_q] != V_IDLE) begin
          env_nxt = env_q[vidx_q];
          st_nxt  = state_q[vidx_q];
          case (state_q[vidx_q])
            V_ATTACK: begin
              env_sum = {1'b0, env_q[vidx_q]} + {1'b0, atk_q[vidx_q]};
              if (env_sum >= {1'b0, lvl_q[vidx_q]}) begin
                env_nxt = lvl_q[vidx_q];
                st_nxt  = V_SUSTAIN;
              end else begin
                env_nxt = env_sum[7:0];
              end
            end
            V_RELEASE: begin
              if (rel_q[vidx_q] == 8'd0 || env_q[vidx_q] <= rel_q[vidx_q]) begin
                env_nxt             = 8'd0;
                st_nxt              = V_IDLE;
                done_pend_d[vidx_q] = 1'b1;
              end else begin
                env_nxt = env_q[vidx_q] - rel_q[vidx_q];
              end
            end
            default: ;
          endcase
          env_d[vidx_q]   = env_nxt;
          state_d[vidx_q] = st_nxt;
          phase_d[vidx_q] = phase_q[vidx_q] + PHASE_W'(step_q[vidx_q]);
          prod            = $signed(rom_data) * $signed({1'b0, env_nxt});
          contrib         = ACC_W'(prod >>> 8);
        end
        acc_d = acc_q + contrib;
        if (vidx_q == VOICE_IDX_W'(NUM_VOICES - 1)) begin
          seq_d = S_OUT;
        end else begin
          vidx_d     = vnext;
          seq_d      = S_ADDR;
          rom_addr_d = phase_q[vnext][PHASE_W-1 -: ROM_ADDR_W];
        end
      end
      default: begin
        // In range when every bit above the sample sign bit matches it.
        if (&acc_q[ACC_W-1:SAMPLE_W-1] || ~|acc_q[ACC_W-1:SAMPLE_W-1])
          sample_d = acc_q[SAMPLE_W-1:0];
        else if (acc_q[ACC_W-1])
          sample_d = {1'b1, {(SAMPLE_W-1){1'b0}}};
        else
          sample_d = {1'b0, {(SAMPLE_W-1){1'b1}}};
        ready_d = 1'b1;
        done_d  = done_pend_q;
        seq_d   = S_IDLE;
      end
    endcase

    if (beat && play_enable) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (state_d[v] == V_ATTACK || state_d[v] == V_SUSTAIN) begin
          dur_d[v] = dur_q[v] - DUR_W'(1);
          if (dur_q[v] == DUR_W'(1)) state_d[v] = V_RELEASE;
        end
      end
    end

    if (load_new_note) begin
      phase_d[voice_to_load] = '0;
      step_d[voice_to_load]  = step_to_load;
      dur_d[voice_to_load]   = duration_to_load;
      lvl_d[voice_to_load]   = level_to_load;
      atk_d[voice_to_load]   = attack_to_load;
      rel_d[voice_to_load]   = release_to_load;
      env_d[voice_to_load]   = (attack_to_load != 8'd0) ? 8'd0 : level_to_load;
      if (duration_to_load == '0)
        state_d[voice_to_load] = V_RELEASE;
      else
        state_d[voice_to_load] = (attack_to_load != 8'd0) ? V_ATTACK : V_SUSTAIN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase_q[v] <= '0;
        step_q[v]  <= '0;
        dur_q[v]   <= '0;
        lvl_q[v]   <= '0;
        atk_q[v]   <= '0;
        rel_q[v]   <= '0;
        env_q[v]   <= '0;
        state_q[v] <= V_IDLE;
      end
      seq_q       <= S_IDLE;
      vidx_q      <= '0;
      acc_q       <= '0;
      rom_addr_q  <= '0;
      sample_q    <= '0;
      ready_q     <= 1'b0;
      done_q      <= '0;
      done_pend_q <= '0;
    end else begin
      phase_q     <= phase_d;
      step_q      <= step_d;
      dur_q       <= dur_d;
      lvl_q       <= lvl_d;
      atk_q       <= atk_d;
      rel_q       <= rel_d;
      env_q       <= env_d;
      state_q     <= state_d;
      seq_q       <= seq_d;
      vidx_q      <= vidx_d;
      acc_q       <= acc_d;
      rom_addr_q  <= rom_addr_d;
      sample_q    <= sample_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      done_pend_q <= done_pend_d;
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_active
    assign voice_active[v] = (state_q[v] != V_IDLE);
  end

  assign rom_addr         = rom_addr_q;
  assign sample_out       = sample_q;
  assign new_sample_ready = ready_q;
  assign done_with_note   = done_q;

endmodule
`default_nettype wire

// File: doc/poly_note_player.md
Name: poly_note_player

Overview:
- Parametrised, polyphonic successor to the single-voice note player.
- Holds NUM_VOICES independent voices. Each voice has a phase accumulator, a beat-counted duration and a linear attack/release envelope with a programmable level.
- On each generate_next_sample request, one time-multiplexed pass reads the shared sine ROM once per voice, scales each value by that voice's envelope, sums the voices and saturates the result.
- Sits between the song reader (note loads, beat) and the codec sample interface.

Parameters:
NUM_VOICES, 4, number of voices (power of two, 1..16)
VOICE_IDX_W, 2, log2(NUM_VOICES), minimum 1
PHASE_W, 22, phase accumulator width
STEP_W, 20, phase increment width
ROM_ADDR_W, 10, sine ROM address width
SAMPLE_W, 16, signed sample width
DUR_W, 6, duration width (beats)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
play_enable  in  1  1 = play; 0 = pause (voice state frozen)
beat  in  1  one-cycle beat pulse
load_new_note  in  1  one-cycle load strobe
voice_to_load  in  VOICE_IDX_W  target voice index
step_to_load  in  STEP_W  phase increment (from frequency ROM)
duration_to_load  in  DUR_W  note length in beats
level_to_load  in  8  sustain level L (0..255)
attack_to_load  in  8  envelope increment per sample (0 = instant)
release_to_load  in  8  envelope decrement per sample (0 = instant)
generate_next_sample  in  1  one-cycle sample request
rom_addr  out  ROM_ADDR_W  sine ROM address = top ROM_ADDR_W bits of phase
rom_data  in  SAMPLE_W  signed ROM output, valid one edge after rom_addr
sample_out  out  SAMPLE_W  signed mixed sample
new_sample_ready  out  1  one-cycle pulse: sample_out updated
done_with_note  out  NUM_VOICES  per-voice one-cycle pulse when the voice goes idle
voice_active  out  NUM_VOICES  per-voice flag: voice state != IDLE

Behaviour:
- Reset (async): all voices IDLE; phase, env and duration = 0; sample_out = 0, new_sample_ready = 0, done_with_note = 0, rom_addr = 0, sequencer idle.
- Voice states: IDLE, ATTACK, SUSTAIN, RELEASE.
- Load (any cycle, including mid-pass) sets the indexed voice to: phase = 0, step, L, atk, rel, dur = duration_to_load.
  - State after load: ATTACK with env = 0 if atk != 0; SUSTAIN with env = L if atk == 0.
  - If dur == 0, state is RELEASE regardless of atk.
  - Load beats a same-cycle beat or sequencer update for that voice.
- Beat with play_enable = 1: every voice in ATTACK/SUSTAIN decrements dur. dur reaching 0 moves the voice to RELEASE. Beats are ignored while paused.
- Sequencer states: S_IDLE, S_ADDR, S_ACC, S_OUT.
  - generate_next_sample is accepted only in S_IDLE and ignored while a pass is running.
  - For v = 0..NUM_VOICES-1: S_ADDR drives rom_addr from voice v's phase; S_ACC captures rom_data.
  - Latency: new_sample_ready pulses exactly 2*NUM_VOICES+1 cycles after the accepting edge (9 cycles for NUM_VOICES = 4), with sample_out valid in the same cycle.
- Per-voice update in S_ACC, only when play_enable = 1 and the voice is not IDLE:
  - ATTACK: env = min(env + atk, L); env == L -> SUSTAIN.
  - SUSTAIN: env holds.
  - RELEASE: env = max(env - rel, 0), or 0 if rel == 0; env == 0 -> IDLE and done_with_note[v] pulses in the S_OUT cycle.
  - phase += step, modulo 2^PHASE_W (wraps).
- Contribution per voice: (rom_data * env_after_update) >>> 8, arithmetic shift (floor). IDLE voices contribute 0 and do not advance phase.
- Mixing: sum in a SAMPLE_W+VOICE_IDX_W signed accumulator, then saturate to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
- Paused (play_enable = 0): requests still complete with the same latency; sample_out = 0; phase, env, dur and state are all frozen.
- Voice loaded mid-pass: a contribution already accumulated this pass stands. The new values take effect from the next time that voice is visited.

Test Plan:
- Constant-ROM bench (rom_data = 20000). Load voice 0 with L = 255, atk = 0, dur = 10; request -> new_sample_ready exactly 9 cycles later, sample_out = 19921.
- rom_data = 256; load voice 1 with L = 200, atk = 64; four requests -> sample_out = 64, 128, 192, 200; voice 1 in SUSTAIN after the 4th.
- All 4 voices with L = 255, atk = 0: rom_data = 20000 -> sample_out = 32767; rom_data = -20000 -> sample_out = -32768 (saturation both ways).
- Voice 2 with dur = 3, rel = 0: three beats, then one request -> done_with_note[2] pulses once with new_sample_ready; voice_active[2] = 0.
- Pause: play_enable = 0 for 5 requests and 3 beats -> sample_out = 0 each time. After resume, the next sample matches the value the next request would have produced before the pause; dur is unchanged.
- Assert reset mid-pass -> outputs 0 immediately (asynchronous), all voice_active = 0, no new_sample_ready. The next request yields 0.
